// File: rtl/flex_counter_mc.sv
`default_nettype none
// ============================================================================
// Module      : flex_counter_mc
// Description : NUM_CH independent flexible counters (up/down, wrap/one-shot/
//               saturate, load, clear) sharing clk/nrst and an optional
//               prescaler enabled by FLEX_CNT_PRESCALE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module flex_counter_mc #(
    parameter int NUM_CNT_BITS  = 8,
    parameter int NUM_CH        = 4,
    parameter int PRESCALE_BITS = 8
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic [NUM_CH-1:0]              count_enable,
    input  logic [NUM_CH-1:0]              clear,
    input  logic [NUM_CH-1:0]              load,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
    input  logic [NUM_CH-1:0]              dir,
    input  logic [2*NUM_CH-1:0]            mode,
    input  logic [PRESCALE_BITS-1:0]       prescale_val,
    output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
    output logic [NUM_CH-1:0]              rollover_flag,
    output logic [NUM_CH-1:0]              rollover_pulse,
    output logic [NUM_CH-1:0]              done
);

    localparam logic [NUM_CNT_BITS-1:0]  c_ONE     = 1;
    localparam logic [PRESCALE_BITS-1:0] c_PRE_ONE = 1;

    logic w_tick;

`ifdef FLEX_CNT_PRESCALE_EN
    logic [PRESCALE_BITS-1:0] r_prescaler;

    // >= keeps the prescaler bounded if prescale_val is lowered mid-count
    assign w_tick = (r_prescaler >= prescale_val);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)       r_prescaler <= '0;
        else if (w_tick) r_prescaler <= '0;
        else             r_prescaler <= r_prescaler + c_PRE_ONE;
    end
`else
    logic w_unused_prescale;
    assign w_unused_prescale = ^prescale_val;
    assign w_tick            = 1'b1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [NUM_CNT_BITS-1:0] r_cnt;
        logic                    r_flag;
        logic                    r_pulse;
        logic                    r_done;
        logic [NUM_CNT_BITS-1:0] w_rv;
        logic [NUM_CNT_BITS-1:0] w_term;
        logic [NUM_CNT_BITS-1:0] w_step_val;
        logic [NUM_CNT_BITS-1:0] w_next;
        logic [1:0]              w_mode;
        logic                    w_wrap;
        logic                    w_oneshot;
        logic                    w_step;
        logic                    w_moved;
        logic                    w_pulse_nxt;
        logic                    w_done_nxt;

        assign w_rv      = rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS];
        assign w_mode    = mode[2*i +: 2];
        assign w_wrap    = (w_mode == 2'b00) || (w_mode == 2'b11);
        assign w_oneshot = (w_mode == 2'b01);
        assign w_term    = dir[i] ? '0 : w_rv;
        assign w_step    = count_enable[i] & w_tick & ~r_done;

        // w_moved marks a real step; a wrap that lands on the same value
        // (R==1 up) still counts, a boundary hold does not.
        always_comb begin
            w_step_val = r_cnt;
            w_moved    = 1'b0;
            if (!dir[i]) begin
                if (w_rv == '0) begin
                    w_step_val = '0;
                    w_moved    = (r_cnt != '0);
                end else if (r_cnt < w_rv) begin
                    w_step_val = r_cnt + c_ONE;
                    w_moved    = 1'b1;
                end else if (w_wrap) begin
                    w_step_val = c_ONE;
                    w_moved    = 1'b1;
                end
            end else begin
                if (r_cnt != '0) begin
                    w_step_val = r_cnt - c_ONE;
                    w_moved    = 1'b1;
                end else if (w_wrap) begin
                    w_step_val = w_rv;
                    w_moved    = 1'b1;
                end
            end
        end

        always_comb begin
            w_next      = r_cnt;
            w_pulse_nxt = 1'b0;
            w_done_nxt  = r_done;
            if (clear[i]) begin
                w_next     = '0;
                w_done_nxt = 1'b0;
            end else if (load[i]) begin
                w_next     = load_val[i*NUM_CNT_BITS +: NUM_CNT_BITS];
                w_done_nxt = 1'b0;
            end else if (w_step) begin
                w_next = w_step_val;
                if (w_moved && (w_step_val == w_term)) begin
                    w_pulse_nxt = 1'b1;
                    w_done_nxt  = w_oneshot;
                end
            end
        end

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                r_cnt   <= '0;
                r_flag  <= 1'b0;
                r_pulse <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                r_cnt   <= w_next;
                r_flag  <= (w_next == w_term);
                r_pulse <= w_pulse_nxt;
                r_done  <= w_done_nxt;
            end
        end

        assign count_out[i*NUM_CNT_BITS +: NUM_CNT_BITS] = r_cnt;
        assign rollover_flag[i]  = r_flag;
        assign rollover_pulse[i] = r_pulse;
        assign done[i]           = r_done;
    end

endmodule
`default_nettype wire

// File: tb/tb_flex_counter_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_flex_counter_mc
// Description : Scoreboard bench for flex_counter_mc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flex_counter_mc;

    localparam int W = 8;
    localparam int N = 4;
    localparam int P = 8;

    logic           clk = 1'b0;
    logic           nrst;
    logic [N-1:0]   count_enable, clear, load, dir;
    logic [N*W-1:0] load_val, rollover_val, count_out;
    logic [2*N-1:0] mode;
    logic [P-1:0]   prescale_val;
    logic [N-1:0]   rollover_flag, rollover_pulse, done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string        tag;
        int           ch;
        logic [W-1:0] cnt;
        logic         flag;
        logic         pulse;
        logic         dn;
    } exp_t;

    exp_t sb[$];

    flex_counter_mc #(
        .NUM_CNT_BITS (W),
        .NUM_CH       (N),
        .PRESCALE_BITS(P)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .count_enable  (count_enable),
        .clear         (clear),
        .load          (load),
        .load_val      (load_val),
        .rollover_val  (rollover_val),
        .dir           (dir),
        .mode          (mode),
        .prescale_val  (prescale_val),
        .count_out     (count_out),
        .rollover_flag (rollover_flag),
        .rollover_pulse(rollover_pulse),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input string tag, input int ch, input int cnt,
                        input logic flag, input logic pulse, input logic dn);
        exp_t e;
        e.tag = tag; e.ch = ch; e.cnt = cnt[W-1:0];
        e.flag = flag; e.pulse = pulse; e.dn = dn;
        sb.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".cnt"},   32'(count_out[e.ch*W +: W]), 32'(e.cnt));
            chk({e.tag, ".flag"},  32'(rollover_flag[e.ch]),    32'(e.flag));
            chk({e.tag, ".pulse"}, 32'(rollover_pulse[e.ch]),   32'(e.pulse));
            chk({e.tag, ".done"},  32'(done[e.ch]),             32'(e.dn));
        end
    endtask

    task automatic set_r(input int ch, input int v);
        rollover_val[ch*W +: W] = v[W-1:0];
    endtask

    task automatic set_lv(input int ch, input int v);
        load_val[ch*W +: W] = v[W-1:0];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq1[8];
        int seq2[7];
        int seq3[7];
        seq1 = '{1, 2, 3, 1, 2, 3, 1, 2};
        seq2 = '{4, 3, 2, 1, 0, 0, 0};
        seq3 = '{1, 2, 3, 4, 4, 4, 4};

        nrst = 1'b0;
        count_enable = '0; clear = '0; load = '0; dir = '0; mode = '0;
        load_val = '0; rollover_val = '0; prescale_val = '0;
        #12;
        chk("rst.cnt",   32'(count_out),      32'h0);
        chk("rst.flag",  32'(rollover_flag),  32'h0);
        chk("rst.pulse", 32'(rollover_pulse), 32'h0);
        chk("rst.done",  32'(done),           32'h0);
        @(posedge clk); #1;
        nrst = 1'b1;

        // 1: ch0 up wrap R=3
        set_r(0, 3);
        count_enable[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push("t1", 0, seq1[k], seq1[k] == 3, seq1[k] == 3, 1'b0);
            cycle();
        end
        count_enable[0] = 1'b0;

        // 2: ch1 down one-shot
        set_r(1, 7); dir[1] = 1'b1; mode[3:2] = 2'b01;
        set_lv(1, 5); load[1] = 1'b1;
        push("t2ld", 1, 5, 1'b0, 1'b0, 1'b0);
        cycle();
        load[1] = 1'b0; count_enable[1] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            push("t2", 1, seq2[k], seq2[k] == 0, k == 4, k >= 4);
            cycle();
        end
        count_enable[1] = 1'b0;
        set_lv(1, 2); load[1] = 1'b1;
        push("t2rel", 1, 2, 1'b0, 1'b0, 1'b0);
        cycle();
        load[1] = 1'b0;

        // 3: ch2 up saturate, then raise R
        set_r(2, 4); mode[5:4] = 2'b10; count_enable[2] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            push("t3", 2, seq3[k], seq3[k] == 4, k == 3, 1'b0);
            cycle();
        end
        set_r(2, 6);
        push("t3r5", 2, 5, 1'b0, 1'b0, 1'b0);
        cycle();
        push("t3r6", 2, 6, 1'b1, 1'b1, 1'b0);
        cycle();
        count_enable[2] = 1'b0;

        // 4: ch3 priority clear > load > step
        set_r(3, 10); count_enable[3] = 1'b1;
        push("t4a", 3, 1, 1'b0, 1'b0, 1'b0);
        cycle();
        push("t4b", 3, 2, 1'b0, 1'b0, 1'b0);
        cycle();
        clear[3] = 1'b1; load[3] = 1'b1; set_lv(3, 7);
        push("t4clr", 3, 0, 1'b0, 1'b0, 1'b0);
        cycle();
        clear[3] = 1'b0;
        push("t4ld", 3, 7, 1'b0, 1'b0, 1'b0);
        cycle();
        load[3] = 1'b0;
        push("t4st", 3, 8, 1'b0, 1'b0, 1'b0);
        cycle();
        count_enable[3] = 1'b0;

        // 5: ch0 R=0 up, then load above R and step
        set_r(0, 0); clear[0] = 1'b1;
        push("t5clr", 0, 0, 1'b1, 1'b0, 1'b0);
        cycle();
        clear[0] = 1'b0; count_enable[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push("t5r0", 0, 0, 1'b1, 1'b0, 1'b0);
            cycle();
        end
        count_enable[0] = 1'b0; set_r(0, 5); set_lv(0, 9); load[0] = 1'b1;
        push("t5ld", 0, 9, 1'b0, 1'b0, 1'b0);
        cycle();
        load[0] = 1'b0; count_enable[0] = 1'b1;
        push("t5wr", 0, 1, 1'b0, 1'b0, 1'b0);
        cycle();
        count_enable[0] = 1'b0;

        // 6: prescaler pacing, then async reset mid-count
        set_r(0, 100); prescale_val = 8'd2;
        nrst = 1'b0;
        #1;
        nrst = 1'b1;
        count_enable[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
`ifdef FLEX_CNT_PRESCALE_EN
            push("t6", 0, k / 3, 1'b0, 1'b0, 1'b0);
`else
            push("t6", 0, k, 1'b0, 1'b0, 1'b0);
`endif
            cycle();
        end
        #2;
        nrst = 1'b0;
        #1;
        chk("async.cnt",   32'(count_out),      32'h0);
        chk("async.flag",  32'(rollover_flag),  32'h0);
        chk("async.pulse", 32'(rollover_pulse), 32'h0);
        chk("async.done",  32'(done),           32'h0);
        nrst = 1'b1;
        count_enable = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
